mod_exp_ctrl: RTL

- Left-to-right square-and-multiply sequencer computing result = base^exp mod m.
- Sits directly upstream of the interleaved modular multiplier (mod_mul_il_v3). Issues one-cycle multiply requests on that multiplier's a/b/m/enable_p interface and consumes its y/done_irq_p.
- Multiplier is instantiated outside this block; all multiplier traffic goes through mul_* ports.

---
 rtl/mod_exp_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mod_exp_ctrl
// Brief   : Left-to-right square-and-multiply sequencer driving an external
//           modular multiplier; computes result = base^exp mod m.
// Rev     : 1.0 - initial release
// ---------------------------------------------------------------------------
module mod_exp_ctrl #(
  parameter int NBITS = 4096,
  parameter int EBITS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             done_p,
  output logic             mul_enable_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  output logic [NBITS-1:0] mul_m,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_p
);

  localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SQR_ISSUE = 3'd1,
    S_SQR_WAIT  = 3'd2,
    S_MUL_ISSUE = 3'd3,
    S_MUL_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS-1:0] r_acc;
  logic [NBITS-1:0] w_acc_nxt;
  logic [NBITS-1:0] r_base;
  logic [NBITS-1:0] r_mul_m;
  logic [NBITS-1:0] r_result;
  logic [EBITS-1:0] r_exp;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic             w_latch;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_p) begin
          w_latch     = 1'b1;
          // Accumulator starts at 1 mod m, which is 0 when m == 1
          w_acc_nxt   = {{(NBITS-1){1'b0}}, (m != NBITS'(1))};
          w_idx_nxt   = IW'(EBITS - 1);
          w_state_nxt = S_SQR_ISSUE;
        end
      end
      S_SQR_ISSUE: w_state_nxt = S_SQR_WAIT;
      S_SQR_WAIT: begin
        if (mul_done_p) begin
          w_acc_nxt = mul_y;
          if (r_exp[r_idx]) begin
            w_state_nxt = S_MUL_ISSUE;
          end else if (r_idx == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx - IW'(1);
            w_state_nxt = S_SQR_ISSUE;
          end
        end
      end
      S_MUL_ISSUE: w_state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (mul_done_p) begin
          w_acc_nxt = mul_y;
          if (r_idx == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx - IW'(1);
            w_state_nxt = S_SQR_ISSUE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_idx    <= '0;
      r_base   <= '0;
      r_exp    <= '0;
      r_mul_m  <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      if (w_latch) begin
        r_base  <= base;
        r_exp   <= exp;
        r_mul_m <= m;
      end
      // Loading on DONE entry makes the final product visible during DONE
      if (w_state_nxt == S_DONE) begin
        r_result <= w_acc_nxt;
      end
    end
  end

  // Accumulator only changes on the edge leaving a WAIT state, so operands
  // derived from it stay stable from each request until its completion.
  always_comb begin
    mul_a        = '0;
    mul_b        = '0;
    mul_enable_p = 1'b0;
    case (r_state)
      S_SQR_ISSUE: begin
        mul_a        = r_acc;
        mul_b        = r_acc;
        mul_enable_p = 1'b1;
      end
      S_SQR_WAIT: begin
        mul_a = r_acc;
        mul_b = r_acc;
      end
      S_MUL_ISSUE: begin
        mul_a        = r_acc;
        mul_b        = r_base;
        mul_enable_p = 1'b1;
      end
      S_MUL_WAIT: begin
        mul_a = r_acc;
        mul_b = r_base;
      end
      default: begin
        mul_a        = '0;
        mul_b        = '0;
        mul_enable_p = 1'b0;
      end
    endcase
  end

  assign mul_m  = r_mul_m;
  assign result = r_result;
  assign busy   = (r_state != S_IDLE);
  assign done_p = (r_state == S_DONE);

endmodule
`default_nettype wire
